// File: rtl/lsu_mem_if.sv
// Data bus between the load/store unit (master) and the memory port (slave).
// Request fields are meaningful only while req is high; err qualifies rvalid.
interface lsu_mem_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/lsu_mem.sv
// Memory stage load/store unit: issues one bus transaction per memory op,
// stalls the pipeline until the response arrives, then writes back once.
module lsu_mem (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        inst_valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_wa_i,
    input  logic [31:0] rd_wd_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wa_i,
    input  logic [31:0] csr_wd_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_wa_o,
    output logic [31:0] rd_wd_o,
    output logic        csr_we_o,
    output logic [31:0] csr_wa_o,
    output logic [31:0] csr_wd_o,
    output logic        stall_req_o,
    lsu_mem_if.master   dbus,
    output logic        exc_misalign_o,
    output logic        exc_buserr_o,
    output logic [31:0] exc_addr_o
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ABORT
    } state_t;

    function automatic logic is_byte(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] off);
        if (is_byte(op))      return 4'b0001 << off;
        else if (is_half(op)) return off[1] ? 4'b1100 : 4'b0011;
        else if (is_word(op)) return 4'b1111;
        else                  return 4'b0000;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
        if (is_byte(op))      return {4{wd[7:0]}};
        else if (is_half(op)) return {2{wd[15:0]}};
        else                  return wd;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   return {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  return {24'd0, lane[7:0]};
            OP_LH:   return {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  return {16'd0, lane[15:0]};
            default: return rdata;
        endcase
    endfunction

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [4:0]  rd_wa_q;
    logic [31:0] result_q;
    logic        err_q;
    logic        drop_wb_q;

    logic        mem_op;
    logic        misalign;
    logic        issue;
    logic        req;
    logic [3:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;

    assign mem_op   = inst_valid_i && (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
    assign misalign = mem_op && ((is_half(mem_op_i) && mem_addr_i[0]) ||
                                 (is_word(mem_op_i) && (mem_addr_i[1:0] != 2'b00)));
    assign issue    = mem_op && !misalign && !flush_i;

    // The first request cycle drives the bus straight from the inputs; afterwards from the captured copy.
    assign sel_op   = (state == S_IDLE) ? mem_op_i   : op_q;
    assign sel_addr = (state == S_IDLE) ? mem_addr_i : addr_q;
    assign sel_wd   = (state == S_IDLE) ? mem_wd_i   : wd_q;

    assign dbus.req   = req;
    assign dbus.we    = is_store(sel_op);
    assign dbus.be    = byte_en(sel_op, sel_addr[1:0]);
    assign dbus.addr  = {sel_addr[31:2], 2'b00};
    assign dbus.wdata = store_data(sel_op, sel_wd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            rd_wa_q   <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            drop_wb_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q    <= mem_op_i;
                        addr_q  <= mem_addr_i;
                        wd_q    <= mem_wd_i;
                        rd_wa_q <= rd_wa_i;
                        state   <= dbus.gnt ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (dbus.gnt)    state <= S_WAIT;
                    else if (flush_i) state <= S_IDLE;
                end
                S_WAIT: begin
                    // A response arriving with a flush still completes, but without writeback.
                    if (dbus.rvalid) begin
                        result_q  <= load_fmt(op_q, addr_q[1:0], dbus.rdata);
                        err_q     <= dbus.err;
                        drop_wb_q <= flush_i;
                        state     <= S_DONE;
                    end else if (flush_i) begin
                        state <= S_ABORT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: if (dbus.rvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_we_o        = 1'b0;
        rd_wa_o        = rd_wa_q;
        rd_wd_o        = result_q;
        csr_we_o       = 1'b0;
        csr_wa_o       = '0;
        csr_wd_o       = '0;
        stall_req_o    = 1'b0;
        req            = 1'b0;
        exc_misalign_o = 1'b0;
        exc_buserr_o   = 1'b0;
        exc_addr_o     = '0;
        case (state)
            S_IDLE: begin
                rd_wa_o  = rd_wa_i;
                rd_wd_o  = rd_wd_i;
                csr_wa_o = csr_wa_i;
                csr_wd_o = csr_wd_i;
                if (!mem_op) begin
                    rd_we_o  = rd_we_i;
                    csr_we_o = csr_we_i;
                end else if (misalign) begin
                    exc_misalign_o = 1'b1;
                    exc_addr_o     = mem_addr_i;
                end else if (!flush_i) begin
                    req         = 1'b1;
                    stall_req_o = 1'b1;
                end
            end
            S_REQ: begin
                req         = 1'b1;
                stall_req_o = 1'b1;
            end
            S_WAIT, S_ABORT: stall_req_o = 1'b1;
            S_DONE: begin
                rd_we_o = is_load(op_q) && !err_q && !drop_wb_q;
                if (err_q) begin
                    exc_buserr_o = 1'b1;
                    exc_addr_o   = addr_q;
                end
            end
            default: ;
        endcase
        if (rst_i) begin
            req            = 1'b0;
            stall_req_o    = 1'b0;
            exc_misalign_o = 1'b0;
            exc_buserr_o   = 1'b0;
            exc_addr_o     = '0;
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed and randomized transactions on lsu_mem, checked against a
// transaction-level model of byte lanes, alignment and the stall/writeback rules.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inst_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        rd_we_i;
    logic [4:0]  rd_wa_i;
    logic [31:0] rd_wd_i;
    logic        csr_we_i;
    logic [31:0] csr_wa_i;
    logic [31:0] csr_wd_i;
    logic        rd_we_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o;
    logic        csr_we_o;
    logic [31:0] csr_wa_o;
    logic [31:0] csr_wd_o;
    logic        stall_req_o;
    logic        exc_misalign_o;
    logic        exc_buserr_o;
    logic [31:0] exc_addr_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_if dbus ();

    lsu_mem dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .inst_valid_i   (inst_valid),
        .mem_op_i       (mem_op),
        .mem_addr_i     (mem_addr),
        .mem_wd_i       (mem_wd),
        .rd_we_i        (rd_we_i),
        .rd_wa_i        (rd_wa_i),
        .rd_wd_i        (rd_wd_i),
        .csr_we_i       (csr_we_i),
        .csr_wa_i       (csr_wa_i),
        .csr_wd_i       (csr_wd_i),
        .rd_we_o        (rd_we_o),
        .rd_wa_o        (rd_wa_o),
        .rd_wd_o        (rd_wd_o),
        .csr_we_o       (csr_we_o),
        .csr_wa_o       (csr_wa_o),
        .csr_wd_o       (csr_wd_o),
        .stall_req_o    (stall_req_o),
        .dbus           (dbus),
        .exc_misalign_o (exc_misalign_o),
        .exc_buserr_o   (exc_buserr_o),
        .exc_addr_o     (exc_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, lanes touched, replicated store data, load result.
    function automatic int unsigned op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input int unsigned size, input int unsigned off);
        logic [3:0] b;
        b = '0;
        for (int unsigned k = 0; k < 4; k++) b[k] = (k >= off) && (k < off + size);
        return b;
    endfunction

    function automatic logic [31:0] exp_wdata(input int unsigned size, input logic [31:0] wd);
        logic [31:0] w;
        w = '0;
        for (int unsigned k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % size) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input int unsigned off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        longint      v;
        longint      span;
        int unsigned size;
        size = op_size(op);
        if (size == 4) return rdata;
        sh   = rdata >> (8 * off);
        span = longint'(1) << (8 * size);
        v    = longint'(sh) % span;
        if ((op == 4'd1 || op == 4'd2) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic quiet();
        inst_valid = 1'b0;
        mem_op     = '0;
        mem_addr   = '0;
        mem_wd     = '0;
        flush      = 1'b0;
        rd_we_i    = 1'b0;
        rd_wa_i    = '0;
        rd_wd_i    = '0;
        csr_we_i   = 1'b0;
        csr_wa_i   = '0;
        csr_wd_i   = '0;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = '0;
        dbus.err    = 1'b0;
    endtask

    // fmode: 0 plain, 1 flush in WAIT before rvalid, 2 flush together with rvalid, 3 flush in REQ
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] wa, input int unsigned g, input int unsigned r,
                           input logic err, input logic [31:0] rdata, input int unsigned fmode);
        int unsigned size;
        int unsigned off;
        logic        is_ld;
        logic        is_st;
        logic        misal;
        logic        wb;
        int unsigned stalls;
        size   = op_size(op);
        off    = addr % 4;
        is_ld  = (op >= 4'd1) && (op <= 4'd5);
        is_st  = (op >= 4'd6) && (op <= 4'd8);
        misal  = (size == 2 && addr % 2 != 0) || (size == 4 && off != 0);
        stalls = 0;

        @(negedge clk);
        inst_valid = 1'b1;
        mem_op     = op;
        mem_addr   = addr;
        mem_wd     = wd;
        rd_we_i    = 1'b1;
        rd_wa_i    = wa;
        rd_wd_i    = $urandom;
        csr_we_i   = 1'b1;
        csr_wa_i   = $urandom;
        csr_wd_i   = $urandom;
        flush      = 1'b0;
        dbus.gnt    = (g == 0);
        dbus.rvalid = 1'b0;
        dbus.err    = 1'b0;
        dbus.rdata  = $urandom;
        #1;
        if (misal) begin
            chk1("misalign_flag", exc_misalign_o, 1'b1);
            chk("misalign_addr", exc_addr_o, addr);
            chk1("misalign_req", dbus.req, 1'b0);
            chk1("misalign_stall", stall_req_o, 1'b0);
            chk1("misalign_rd_we", rd_we_o, 1'b0);
            chk1("misalign_csr_we", csr_we_o, 1'b0);
            @(negedge clk);
            inst_valid = 1'b0;
            #1;
            chk1("misalign_pulse", exc_misalign_o, 1'b0);
            chk1("misalign_no_req", dbus.req, 1'b0);
            return;
        end

        chk1("issue_req", dbus.req, 1'b1);
        chk1("issue_stall", stall_req_o, 1'b1);
        chk1("issue_rd_we", rd_we_o, 1'b0);
        chk("issue_addr", dbus.addr, addr & 32'hFFFF_FFFC);
        chk("issue_be", 32'(dbus.be), 32'(exp_be(size, off)));
        chk1("issue_we", dbus.we, is_st);
        if (is_st) chk("issue_wdata", dbus.wdata, exp_wdata(size, wd));
        stalls += 32'(stall_req_o);

        for (int unsigned c = 1; c <= g; c++) begin
            @(negedge clk);
            inst_valid = 1'b0;
            mem_op     = 4'($urandom);
            mem_addr   = $urandom;
            mem_wd     = $urandom;
            dbus.gnt   = (c == g);
            flush      = (fmode == 3 && c == 1);
            #1;
            chk1("req_held", dbus.req, 1'b1);
            chk1("req_stall", stall_req_o, 1'b1);
            chk("req_addr", dbus.addr, addr & 32'hFFFF_FFFC);
            chk("req_be", 32'(dbus.be), 32'(exp_be(size, off)));
            chk1("req_we", dbus.we, is_st);
            if (is_st) chk("req_wdata", dbus.wdata, exp_wdata(size, wd));
            stalls += 32'(stall_req_o);
            if (fmode == 3) begin
                @(negedge clk);
                flush    = 1'b0;
                dbus.gnt = 1'b0;
                #1;
                chk1("drop_req", dbus.req, 1'b0);
                chk1("drop_stall", stall_req_o, 1'b0);
                return;
            end
        end

        for (int unsigned c = 1; c <= r; c++) begin
            @(negedge clk);
            inst_valid  = 1'b0;
            mem_op      = 4'($urandom);
            mem_addr    = $urandom;
            dbus.gnt    = 1'b0;
            dbus.rvalid = (c == r);
            dbus.rdata  = (c == r) ? rdata : $urandom;
            dbus.err    = (c == r) ? err : 1'($urandom);
            flush       = (fmode == 1 && c == 1) || (fmode == 2 && c == r);
            #1;
            chk1("wait_req", dbus.req, 1'b0);
            chk1("wait_stall", stall_req_o, 1'b1);
            stalls += 32'(stall_req_o);
        end

        @(negedge clk);
        dbus.rvalid = 1'b0;
        dbus.err    = 1'b0;
        flush       = 1'b0;
        rd_we_i     = 1'b0;
        csr_we_i    = 1'b0;
        #1;
        chk("stall_cycles", stalls, g + r + 1);
        chk1("end_stall", stall_req_o, 1'b0);
        chk1("end_csr_we", csr_we_o, 1'b0);
        if (fmode == 1) begin
            chk1("abort_rd_we", rd_we_o, 1'b0);
            chk1("abort_buserr", exc_buserr_o, 1'b0);
        end else begin
            wb = is_ld && !err && (fmode != 2);
            chk1("done_rd_we", rd_we_o, wb);
            if (wb) begin
                chk("done_rd_wd", rd_wd_o, exp_load(op, off, rdata));
                chk("done_rd_wa", 32'(rd_wa_o), 32'(wa));
            end
            chk1("done_buserr", exc_buserr_o, err);
            if (err) chk("done_exc_addr", exc_addr_o, addr);
        end

        @(negedge clk);
        #1;
        chk1("after_buserr", exc_buserr_o, 1'b0);
        chk1("after_stall", stall_req_o, 1'b0);
        chk1("after_rd_we", rd_we_o, 1'b0);
        chk1("after_req", dbus.req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        int unsigned size;
        int unsigned g;
        int unsigned r;
        int unsigned fm;
        logic        err;
        logic        v;

        quiet();
        rst = 1'b1;

        // Held in reset with a valid aligned load and then a misaligned one.
        @(negedge clk);
        inst_valid = 1'b1;
        mem_op     = 4'd3;
        mem_addr   = 32'h0000_0100;
        #1;
        chk1("rst_req", dbus.req, 1'b0);
        chk1("rst_stall", stall_req_o, 1'b0);
        chk1("rst_buserr", exc_buserr_o, 1'b0);
        mem_addr = 32'h0000_0101;
        #1;
        chk1("rst_misalign", exc_misalign_o, 1'b0);
        chk("rst_exc_addr", exc_addr_o, 32'h0);
        @(negedge clk);
        quiet();
        rst = 1'b0;

        // Non-memory instructions pass the writeback fields through.
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            v          = 1'($urandom);
            inst_valid = v;
            mem_op     = v ? ((i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15))) : 4'($urandom);
            mem_addr   = $urandom;
            rd_we_i    = 1'($urandom);
            rd_wa_i    = 5'($urandom);
            rd_wd_i    = $urandom;
            csr_we_i   = 1'($urandom);
            csr_wa_i   = $urandom;
            csr_wd_i   = $urandom;
            #1;
            chk1("pass_rd_we", rd_we_o, rd_we_i);
            chk("pass_rd_wa", 32'(rd_wa_o), 32'(rd_wa_i));
            chk("pass_rd_wd", rd_wd_o, rd_wd_i);
            chk1("pass_csr_we", csr_we_o, csr_we_i);
            chk("pass_csr_wa", csr_wa_o, csr_wa_i);
            chk("pass_csr_wd", csr_wd_o, csr_wd_i);
            chk1("pass_stall", stall_req_o, 1'b0);
            chk1("pass_req", dbus.req, 1'b0);
        end
        @(negedge clk);
        quiet();

        run_txn(4'd1, 32'h0000_1003, 32'h0, 5'd3, 0, 2, 1'b0, 32'h80FF_FFFF, 0);
        run_txn(4'd7, 32'h0000_2002, 32'h0000_BEEF, 5'd4, 3, 1, 1'b0, 32'h1234_5678, 0);
        run_txn(4'd3, 32'h0000_3001, 32'h0, 5'd5, 0, 1, 1'b0, 32'h0, 0);
        run_txn(4'd5, 32'h0000_4002, 32'h0, 5'd6, 0, 1, 1'b1, 32'hCAFE_F00D, 0);
        run_txn(4'd3, 32'h0000_3000, 32'h0, 5'd7, 0, 3, 1'b0, 32'hDEAD_BEEF, 1);
        run_txn(4'd3, 32'h0000_3004, 32'h0, 5'd8, 1, 1, 1'b0, 32'h0BAD_F00D, 2);
        run_txn(4'd8, 32'h0000_6000, 32'h1122_3344, 5'd9, 3, 1, 1'b0, 32'h0, 3);

        // Reset pulse while waiting for a response, then a stray response.
        @(negedge clk);
        inst_valid = 1'b1;
        mem_op     = 4'd3;
        mem_addr   = 32'h0000_5000;
        dbus.gnt   = 1'b1;
        #1;
        chk1("rw_issue_req", dbus.req, 1'b1);
        @(negedge clk);
        quiet();
        #1;
        chk1("rw_wait_stall", stall_req_o, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rw_rst_req", dbus.req, 1'b0);
        chk1("rw_rst_stall", stall_req_o, 1'b0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        dbus.rvalid = 1'b1;
        dbus.err    = 1'b1;
        dbus.rdata  = 32'hFFFF_FFFF;
        #1;
        chk1("stray_stall", stall_req_o, 1'b0);
        chk1("stray_rd_we", rd_we_o, 1'b0);
        chk1("stray_buserr", exc_buserr_o, 1'b0);
        @(negedge clk);
        quiet();
        #1;
        chk1("stray_after_rd_we", rd_we_o, 1'b0);
        chk1("stray_after_buserr", exc_buserr_o, 1'b0);
        chk1("stray_after_stall", stall_req_o, 1'b0);

        for (int unsigned i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(1, 8));
            size = op_size(op);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(size - 1);
            g   = $urandom_range(0, 3);
            r   = $urandom_range(1, 3);
            err = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                7:       fm = (r >= 2) ? 1 : 0;
                8:       fm = 2;
                9:       fm = (g >= 2) ? 3 : 0;
                default: fm = 0;
            endcase
            if (fm == 2) err = 1'b0;
            run_txn(op, addr, $urandom, 5'($urandom), g, r, err, $urandom, fm);
        end

        @(negedge clk);
        quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
